// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the write-back stage.
// MEM_WB and decode use these same definitions, so the control bit
// positions and the widths stay consistent across all three blocks.
package wb_regfile_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_NREGS  = 32;
  localparam int WB_ADDR_W = $clog2(WB_NREGS);

  // Write-back control word carried in MEM/WB: {RegWrite, MemtoReg}
  localparam int CTRL_W        = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  // r0 is hardwired, so a write aimed at it is dropped at the source.
  // Qualifying the enable here also keeps the bypass from ever matching r0.
  function automatic logic reg_write_q(input logic [CTRL_W-1:0] ctrl,
                                       input logic [WB_ADDR_W-1:0] wa);
    return ctrl[CTRL_REGWRITE] && (wa != '0);
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// Write-back / register-read bus.
//   master : the pipeline side. It drives the MEM/WB fields and the decode
//            read indices, and it receives the read data and the WB result.
//   slave  : the register file.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
);
  logic [CTRL_W-1:0] mem_control_wb;
  logic [DATA_W-1:0] read_data;
  logic [DATA_W-1:0] mem_ALU_result;
  logic [ADDR_W-1:0] mem_write_reg;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] wb_write_data;
  logic              wb_reg_write;

  modport master (
    output mem_control_wb, read_data, mem_ALU_result, mem_write_reg,
           rs_addr, rt_addr,
    input  rs_data, rt_data, wb_write_data, wb_reg_write
  );

  modport slave (
    input  mem_control_wb, read_data, mem_ALU_result, mem_write_reg,
           rs_addr, rt_addr,
    output rs_data, rt_data, wb_write_data, wb_reg_write
  );
endinterface

// File: rtl/wb_regfile_mux.sv
// Write-back source select.
//   mem_to_reg : 1 selects the load value, 0 selects the ALU result
//   read_data  : load value from MEM/WB
//   alu_result : ALU result from MEM/WB
//   wb_data    : selected value (combinational)
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data
);
  assign wb_data = mem_to_reg ? read_data : alu_result;
endmodule

// File: rtl/wb_regfile.sv
// Architectural register file with the write-back stage and write-through bypass.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; clears every register
//   bus   : wb_regfile_if.slave
//           MEM/WB control, load value, ALU result and destination in;
//           two decode read indices in; two read ports out;
//           the write-back value and the qualified write enable out, for forwarding.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int NREGS  = WB_NREGS
) (
  input  logic       clk,
  input  logic       reset,
  wb_regfile_if.slave bus
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] wdata;
  logic              wen;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .mem_to_reg (bus.mem_control_wb[CTRL_MEMTOREG]),
    .read_data  (bus.read_data),
    .alu_result (bus.mem_ALU_result),
    .wb_data    (wdata)
  );

  // The enable is combinational even while reset is held, because forwarding
  // logic downstream looks at it. The write itself is gated by reset below.
  assign wen               = reg_write_q(bus.mem_control_wb, bus.mem_write_reg);
  assign bus.wb_write_data = wdata;
  assign bus.wb_reg_write  = wen;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wen) begin
      regs[bus.mem_write_reg] <= wdata;
    end
  end

  // During reset the write is discarded, so the bypass is discarded too.
  // This keeps the read ports consistent with what storage holds after the edge.
  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    if (reset && wen && (a == bus.mem_write_reg)) return wdata;
    else if (a == '0)                             return '0;
    else                                          return regs[a];
  endfunction

  always_comb begin
    bus.rs_data = rd_port(bus.rs_addr);
    bus.rt_data = rd_port(bus.rt_addr);
  end

endmodule
